// File: rtl/alu_op_sequencer.sv
// Buffered issuer for the ALU datapath: software loads {instr, d0, d1} entries, start issues
// them in order, each result is captured SETTLE edges after issue and handed out over valid/ready.
module alu_op_sequencer #(
   parameter int DEPTH  = 8,
   parameter int SETTLE = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_valid,
   output logic                     load_ready,
   input  logic [15:0]              load_instr,
   input  logic [7:0]               load_d0,
   input  logic [7:0]               load_d1,
   input  logic                     start,
   output logic                     busy,
   output logic [15:0]              alu_instruction,
   output logic [7:0]               alu_data0,
   output logic [7:0]               alu_data1,
   input  logic [7:0]               alu_out0,
   input  logic [7:0]               alu_out1,
   input  logic [7:0]               alu_out2,
   input  logic [7:0]               alu_out3,
   input  logic                     alu_of,
   input  logic                     alu_zf,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [7:0]               res_out0,
   output logic [7:0]               res_out1,
   output logic [7:0]               res_out2,
   output logic [7:0]               res_out3,
   output logic                     res_of,
   output logic                     res_zf,
   output logic [$clog2(DEPTH)-1:0] res_index,
   output logic                     done
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] count_reg;
   logic [IW-1:0] idx_reg;
   logic [SW-1:0] settle_reg;
   logic [15:0]   instr_mem [DEPTH];
   logic [7:0]    d0_mem    [DEPTH];
   logic [7:0]    d1_mem    [DEPTH];
   logic          do_write, do_issue, do_capture, do_handshake, is_last;
   logic [IW-1:0] rd_addr;

   assign busy       = (state_reg != IDLE);
   assign load_ready = (state_reg == IDLE) && (count_reg < CW'(DEPTH));

   // Buffer contents need no reset: count_reg == 0 already marks every entry invalid.
   always_ff @(posedge clk) begin
      if (do_write) begin
         instr_mem[count_reg[IW-1:0]] <= load_instr;
         d0_mem[count_reg[IW-1:0]]    <= load_d0;
         d1_mem[count_reg[IW-1:0]]    <= load_d1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next   = state_reg;
      do_write     = 1'b0;
      do_issue     = 1'b0;
      do_capture   = 1'b0;
      do_handshake = 1'b0;
      is_last      = (CW'(idx_reg) == count_reg - CW'(1));
      rd_addr      = idx_reg + IW'(1);
      case (state_reg)
         IDLE: begin
            // An accepted start takes priority over a same-edge write.
            if (start && count_reg != '0) begin
               do_issue   = 1'b1;
               rd_addr    = '0;
               state_next = WAIT;
            end else if (load_valid && load_ready) begin
               do_write = 1'b1;
            end
         end
         WAIT: begin
            if (settle_reg == '0) begin
               do_capture = 1'b1;
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (res_valid && res_ready) begin
               do_handshake = 1'b1;
               state_next   = is_last ? IDLE : WAIT;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg       <= '0;
         idx_reg         <= '0;
         settle_reg      <= '0;
         alu_instruction <= '0;
         alu_data0       <= '0;
         alu_data1       <= '0;
         res_valid       <= 1'b0;
         res_out0        <= '0;
         res_out1        <= '0;
         res_out2        <= '0;
         res_out3        <= '0;
         res_of          <= 1'b0;
         res_zf          <= 1'b0;
         res_index       <= '0;
         done            <= 1'b0;
      end else begin
         done <= do_handshake && is_last;
         if (do_write) count_reg <= count_reg + CW'(1);
         if (do_issue || (do_handshake && !is_last)) begin
            alu_instruction <= instr_mem[rd_addr];
            alu_data0       <= d0_mem[rd_addr];
            alu_data1       <= d1_mem[rd_addr];
            idx_reg         <= rd_addr;
            settle_reg      <= SW'(SETTLE - 1);
         end else if (state_reg == WAIT && settle_reg != '0) begin
            settle_reg <= settle_reg - SW'(1);
         end
         if (do_capture) begin
            res_out0  <= alu_out0;
            res_out1  <= alu_out1;
            res_out2  <= alu_out2;
            res_out3  <= alu_out3;
            res_of    <= alu_of;
            res_zf    <= alu_zf;
            res_index <= idx_reg;
            res_valid <= 1'b1;
         end
         if (do_handshake) begin
            res_valid <= 1'b0;
            if (is_last) begin
               count_reg <= '0;
               idx_reg   <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a combinational pass-through ALU stub;
// inputs are driven and outputs sampled on the falling edge.
module tb_alu_op_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_valid = 1'b0;
   logic        load_ready;
   logic [15:0] load_instr = '0;
   logic [7:0]  load_d0 = '0;
   logic [7:0]  load_d1 = '0;
   logic        start = 1'b0;
   logic        busy;
   logic [15:0] alu_instruction;
   logic [7:0]  alu_data0, alu_data1;
   logic [7:0]  alu_out0, alu_out1, alu_out2, alu_out3;
   logic        alu_of, alu_zf;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [7:0]  res_out0, res_out1, res_out2, res_out3;
   logic        res_of, res_zf;
   logic [2:0]  res_index;
   logic        done;

   int checks = 0;
   int errors = 0;
   int done_count = 0;

   alu_op_sequencer #(.DEPTH(8), .SETTLE(2)) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_ready(load_ready),
      .load_instr(load_instr), .load_d0(load_d0), .load_d1(load_d1),
      .start(start), .busy(busy),
      .alu_instruction(alu_instruction), .alu_data0(alu_data0), .alu_data1(alu_data1),
      .alu_out0(alu_out0), .alu_out1(alu_out1), .alu_out2(alu_out2), .alu_out3(alu_out3),
      .alu_of(alu_of), .alu_zf(alu_zf),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_out0(res_out0), .res_out1(res_out1), .res_out2(res_out2), .res_out3(res_out3),
      .res_of(res_of), .res_zf(res_zf), .res_index(res_index), .done(done)
   );

   always #5 clk = ~clk;

   assign alu_out0 = alu_instruction[7:0];
   assign alu_out1 = alu_instruction[15:8];
   assign alu_out2 = alu_data0;
   assign alu_out3 = alu_data1;
   assign alu_of   = alu_data0[7];
   assign alu_zf   = (alu_data1 == 8'h00);

   always @(posedge clk) if (done === 1'b1) done_count++;

   wire [36:0] got = {res_out0, res_out1, res_out2, res_out3, res_of, res_zf, res_index};

   function automatic logic [36:0] model(input logic [15:0] i, input logic [7:0] a,
                                         input logic [7:0] b, input logic [2:0] ix);
      return {i[7:0], i[15:8], a, b, a[7], (b == 8'h00), ix};
   endfunction

   task automatic load_entry(input logic [15:0] i, input logic [7:0] a, input logic [7:0] b);
      load_valid = 1'b1;
      load_instr = i;
      load_d0    = a;
      load_d1    = b;
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   task automatic wait_res(output bit seen);
      int n = 0;
      while (res_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      seen = (res_valid === 1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, res_valid, done, load_ready} !== 4'b0001) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 0001", {busy, res_valid, done, load_ready});
      end
      checks++;
      if ({alu_instruction, alu_data0, alu_data1} !== 32'h0) begin
         errors++;
         $display("FAIL reset_alu: got %h want 0", {alu_instruction, alu_data0, alu_data1});
      end
      checks++;
      if (got !== 37'h0) begin
         errors++;
         $display("FAIL reset_res: got %h want 0", got);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || load_ready !== 1'b1) begin
         errors++;
         $display("FAIL post_reset: got busy=%b load_ready=%b want 0/1", busy, load_ready);
      end
      $display("reset: done");
   endtask

   task automatic test_single();
      res_ready = 1'b1;
      load_entry(16'h0800, 8'd1, 8'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (alu_instruction !== 16'h0800 || busy !== 1'b1 || res_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_issue: got instr=%h busy=%b rv=%b want 0800/1/0",
                  alu_instruction, busy, res_valid);
      end
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_early: got res_valid=%b want 0", res_valid);
      end
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || got !== {8'h00, 8'h08, 8'h01, 8'h01, 1'b0, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL single_result: got rv=%b res=%h want 1/%h", res_valid, got,
                  {8'h00, 8'h08, 8'h01, 8'h01, 1'b0, 1'b0, 3'd0});
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_done: got done=%b rv=%b busy=%b want 1/0/0", done, res_valid, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL single_done_width: got done=%b want 0", done);
      end
      $display("single: instr=0800 res=%h", got);
   endtask

   task automatic test_full_backpressure();
      logic [15:0] ti [8] = '{16'hFFFF, 16'h1234, 16'hABCD, 16'h5A5A,
                              16'h00FF, 16'h8001, 16'h0F0F, 16'h0800};
      logic [7:0]  ta [8] = '{8'd255, 8'h00, 8'h80, 8'h7F, 8'h0F, 8'hC3, 8'h01, 8'd75};
      logic [7:0]  tb [8] = '{8'd255, 8'h10, 8'h00, 8'h01, 8'hF0, 8'h3C, 8'h00, 8'd25};
      bit seen;
      int d0;
      for (int i = 0; i < 8; i++) load_entry(ti[i], ta[i], tb[i]);
      checks++;
      if (load_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_load_ready: got %b want 0", load_ready);
      end
      load_entry(16'hDEAD, 8'hEE, 8'hEE);
      d0 = done_count;
      res_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wait_res(seen);
         checks++;
         if (!seen) begin
            errors++;
            $display("FAIL full_timeout: entry %0d got no res_valid want 1", i);
         end
         checks++;
         if (got !== model(ti[i], ta[i], tb[i], 3'(i))) begin
            errors++;
            $display("FAIL full_result: entry %0d got %h want %h", i, got,
                     model(ti[i], ta[i], tb[i], 3'(i)));
         end
         $display("full: entry %0d res=%h", i, got);
         if (i == 3) begin
            res_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               checks++;
               if (res_valid !== 1'b1 || got !== model(ti[3], ta[3], tb[3], 3'd3) ||
                   alu_instruction !== ti[3]) begin
                  errors++;
                  $display("FAIL stall_stable: got rv=%b res=%h instr=%h want 1/%h/%h", res_valid,
                           got, alu_instruction, model(ti[3], ta[3], tb[3], 3'd3), ti[3]);
               end
            end
            res_ready = 1'b1;
         end
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL full_done: got done=%b busy=%b want 1/0", done, busy);
      end
      @(negedge clk);
      checks++;
      if (done_count - d0 != 1) begin
         errors++;
         $display("FAIL full_done_count: got %0d want 1", done_count - d0);
      end
   endtask

   task automatic test_start_ignored();
      bit seen;
      int d0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || {alu_instruction, alu_data0, alu_data1} !== 32'h0800_4B19) begin
         errors++;
         $display("FAIL empty_start: got busy=%b alu=%h want 0/08004b19", busy,
                  {alu_instruction, alu_data0, alu_data1});
      end
      load_entry(16'h1111, 8'h11, 8'h22);
      load_entry(16'h2222, 8'h33, 8'h00);
      d0 = done_count;
      // start stays high for the whole run: only the first edge may act on it
      start = 1'b1;
      for (int i = 0; i < 2; i++) begin
         wait_res(seen);
         checks++;
         if (!seen || got !== (i == 0 ? model(16'h1111, 8'h11, 8'h22, 3'd0)
                                      : model(16'h2222, 8'h33, 8'h00, 3'd1))) begin
            errors++;
            $display("FAIL busy_start_result: entry %0d got rv=%b res=%h", i, res_valid, got);
         end
         $display("busy_start: entry %0d res=%h", i, got);
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL busy_start_done: got %b want 1", done);
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || alu_instruction !== 16'h2222 || done_count - d0 != 1) begin
         errors++;
         $display("FAIL busy_start_end: got busy=%b instr=%h dones=%0d want 0/2222/1",
                  busy, alu_instruction, done_count - d0);
      end
   endtask

   task automatic test_zero_flag();
      bit seen;
      load_entry(16'h1234, 8'h00, 8'h00);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_res(seen);
      checks++;
      if (!seen || got !== {8'h34, 8'h12, 8'h00, 8'h00, 1'b0, 1'b1, 3'd0}) begin
         errors++;
         $display("FAIL zero_flag: got rv=%b res=%h want 1/%h", res_valid, got,
                  {8'h34, 8'h12, 8'h00, 8'h00, 1'b0, 1'b1, 3'd0});
      end
      $display("zero_flag: res=%h", got);
      @(negedge clk);
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL zero_done: got %b want 1", done);
      end
   endtask

   task automatic test_collision();
      bit seen;
      load_entry(16'hC0DE, 8'h9C, 8'h05);
      load_valid = 1'b1;
      load_instr = 16'hBEEF;
      load_d0    = 8'h77;
      load_d1    = 8'h00;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      load_valid = 1'b0;
      wait_res(seen);
      checks++;
      if (!seen || got !== model(16'hC0DE, 8'h9C, 8'h05, 3'd0)) begin
         errors++;
         $display("FAIL collision_result: got rv=%b res=%h want 1/%h", res_valid, got,
                  model(16'hC0DE, 8'h9C, 8'h05, 3'd0));
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL collision_single: got done=%b busy=%b want 1/0", done, busy);
      end
      $display("collision: res=%h done=%b", got, done);
   endtask

   task automatic test_reset_mid();
      bit seen;
      int d0;
      load_entry(16'h0101, 8'h02, 8'h03);
      load_entry(16'h0202, 8'h04, 8'h05);
      load_entry(16'h0303, 8'h06, 8'h07);
      d0 = done_count;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_res(seen);
      checks++;
      if (!seen || got !== model(16'h0101, 8'h02, 8'h03, 3'd0)) begin
         errors++;
         $display("FAIL mid_first: got rv=%b res=%h", res_valid, got);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || res_valid !== 1'b0 || alu_instruction !== 16'h0202) begin
         errors++;
         $display("FAIL mid_wait: got busy=%b rv=%b instr=%h want 1/0/0202",
                  busy, res_valid, alu_instruction);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({busy, res_valid, done} !== 3'b000 || {alu_instruction, alu_data0, alu_data1} !== 32'h0 ||
          got !== 37'h0) begin
         errors++;
         $display("FAIL mid_reset: got ctrl=%b alu=%h res=%h want 0", {busy, res_valid, done},
                  {alu_instruction, alu_data0, alu_data1}, got);
      end
      @(negedge clk);
      rst = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || alu_instruction !== 16'h0000) begin
         errors++;
         $display("FAIL mid_restart: got busy=%b instr=%h want 0/0000", busy, alu_instruction);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (done_count != d0) begin
         errors++;
         $display("FAIL mid_no_done: got %0d pulses want 0", done_count - d0);
      end
      $display("reset_mid: busy=%b", busy);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_full_backpressure();
      test_start_ignored();
      test_zero_flag();
      test_collision();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
